// File: rtl/ws2812b_decoder.sv
// ws2812b_decoder
//   Recovers 24-bit GRB words from a WS2812B single-wire strand. Each high
//   pulse is measured in synchronized clock cycles and classified as 0/1 by
//   its width. Bits are assembled MSB-first (G7..G0, R7..R0, B7..B0) and each
//   word is tagged with its LED index. A long low gap (reset/latch) marks the
//   frame boundary.
//
// Ports
//   clk_in         system clock
//   rst_in         asynchronous, active-low reset
//   strand_in      raw asynchronous strand line
//   green_out      G byte of the last accepted word (held)
//   red_out        R byte of the last accepted word (held)
//   blue_out       B byte of the last accepted word (held)
//   led_index_out  index of the word on *_out (held)
//   color_valid    1-cycle pulse when a new word is presented
//   frame_done     1-cycle pulse on a reset gap after a frame with >= 1 word
//   error          1-cycle pulse on any protocol violation
module ws2812b_decoder #(
  parameter  int CLOCK_SPEED  = 100_000_000,
  parameter  int NUM_LEDS     = 20,
  localparam int CounterWidth = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    strand_in,
  output logic [7:0]              green_out,
  output logic [7:0]              red_out,
  output logic [7:0]              blue_out,
  output logic [CounterWidth-1:0] led_index_out,
  output logic                    color_valid,
  output logic                    frame_done,
  output logic                    error
);

  // Timing thresholds in clock cycles (ns * Hz / 1e9, truncated).
  localparam longint unsigned ClkHz = 64'(CLOCK_SPEED);
  localparam int TMinHCyc = int'(ClkHz * 200    / 1_000_000_000);
  localparam int TThrCyc  = int'(ClkHz * 600    / 1_000_000_000);
  localparam int TMaxHCyc = int'(ClkHz * 1000   / 1_000_000_000);
  localparam int ResCyc   = int'(ClkHz * 40_000 / 1_000_000_000);

  localparam int HW   = $clog2(TMaxHCyc + 2);
  localparam int LW   = $clog2(ResCyc + 1);
  localparam int LedW = $clog2(NUM_LEDS + 1);

  localparam logic [HW-1:0]   HMin   = HW'(TMinHCyc);
  localparam logic [HW-1:0]   HThr   = HW'(TThrCyc);
  localparam logic [HW-1:0]   HMax   = HW'(TMaxHCyc);
  localparam logic [HW-1:0]   HOver  = HW'(TMaxHCyc + 1);
  localparam logic [LW-1:0]   LRes   = LW'(ResCyc);
  localparam logic [LW-1:0]   LResM1 = LW'(ResCyc - 1);
  localparam logic [LedW-1:0] LedMax = LedW'(NUM_LEDS);

  typedef enum logic [1:0] {SYNC, ARMED, HIGH} state_t;

  // Synchronizer plus one delayed copy for edge detection.
  logic s1, s2, s2_d;
  logic rise, fall;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) {s2_d, s2, s1} <= 3'b000;
    else         {s2_d, s2, s1} <= {s2, s1, strand_in};
  end

  assign rise = s2 & ~s2_d;
  assign fall = ~s2 & s2_d;

  // High counter holds the number of synchronized high cycles seen so far,
  // so on the fall cycle it equals the full pulse width. The low counter is
  // held at zero while the line is high and counts up to the reset length.
  logic [HW-1:0] hcnt;
  logic [LW-1:0] lcnt;
  logic          res_hit;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcnt <= '0;
      lcnt <= '0;
    end else begin
      if (rise)                     hcnt <= HW'(1);
      else if (s2 && hcnt != HOver) hcnt <= hcnt + 1'b1;

      if (s2)                lcnt <= '0;
      else if (lcnt != LRes) lcnt <= lcnt + 1'b1;
    end
  end

  // True only on the single cycle the low counter steps onto ResCyc.
  assign res_hit = ~s2 & (lcnt == LResM1);

  state_t          state;
  logic [4:0]      bit_cnt;
  logic [LedW-1:0] led_cnt;
  logic [22:0]     shreg;
  logic            bit_val;
  logic [23:0]     word;

  assign bit_val = (hcnt >= HThr);
  assign word    = {shreg, bit_val};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= SYNC;
      bit_cnt       <= '0;
      led_cnt       <= '0;
      shreg         <= '0;
      green_out     <= '0;
      red_out       <= '0;
      blue_out      <= '0;
      led_index_out <= '0;
      color_valid   <= 1'b0;
      frame_done    <= 1'b0;
      error         <= 1'b0;
    end else begin
      color_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      case (state)
        // Wait silently for a full reset gap before trusting any bits.
        SYNC: begin
          if (res_hit) begin
            state   <= ARMED;
            bit_cnt <= '0;
            led_cnt <= '0;
          end
        end
        ARMED: begin
          if (rise) begin
            state <= HIGH;
          end else if (res_hit) begin
            bit_cnt <= '0;
            led_cnt <= '0;
            // A partial word at the gap is a violation and masks frame_done.
            if (bit_cnt != 5'd0)      error      <= 1'b1;
            else if (led_cnt != '0)   frame_done <= 1'b1;
          end
        end
        HIGH: begin
          if (hcnt > HMax) begin
            error <= 1'b1;
            state <= SYNC;
          end else if (fall) begin
            if (hcnt < HMin) begin
              error <= 1'b1;
              state <= SYNC;
            end else begin
              shreg <= {shreg[21:0], bit_val};
              state <= ARMED;
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (led_cnt < LedMax) begin
                  green_out     <= word[23:16];
                  red_out       <= word[15:8];
                  blue_out      <= word[7:0];
                  led_index_out <= led_cnt[CounterWidth-1:0];
                  led_cnt       <= led_cnt + 1'b1;
                  color_valid   <= 1'b1;
                end else begin
                  // Strand longer than NUM_LEDS: drop the word, resync.
                  error <= 1'b1;
                  state <= SYNC;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_decoder.sv
// Directed/randomized bench for ws2812b_decoder at 100 MHz. Inputs change on
// the falling clock edge; a monitor logs output pulses on the falling edge
// into queues that the main sequence compares against expected words.
module tb_ws2812b_decoder;
  localparam int NL = 20;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       strand_in = 1'b0;
  logic [7:0] green_out, red_out, blue_out;
  logic [4:0] led_index_out;
  logic       color_valid, frame_done, error;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint last_fall = 0;

  typedef struct {
    logic [23:0] w;
    int          idx;
    longint      t;
  } cv_t;

  cv_t    cv_q[$];
  longint fd_q[$];
  longint er_q[$];

  ws2812b_decoder #(.CLOCK_SPEED(100_000_000), .NUM_LEDS(NL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .strand_in(strand_in),
    .green_out(green_out), .red_out(red_out), .blue_out(blue_out),
    .led_index_out(led_index_out), .color_valid(color_valid),
    .frame_done(frame_done), .error(error)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (color_valid)
      cv_q.push_back('{w: {green_out, red_out, blue_out}, idx: int'(led_index_out), t: cyc});
    if (frame_done) fd_q.push_back(cyc);
    if (error)      er_q.push_back(cyc);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    cv_q.delete(); fd_q.delete(); er_q.delete();
  endtask

  task automatic hold_low(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // High for h clock cycles, then low for l cycles (l >= 1).
  task automatic send_bit(input int h, input int l);
    @(negedge clk_in);
    strand_in = 1'b1;
    repeat (h) @(negedge clk_in);
    strand_in = 1'b0;
    last_fall = cyc + 1;  // first rising edge that samples the low level
    repeat (l - 1) @(negedge clk_in);
  endtask

  task automatic send_rbit(input logic b);
    int h;
    h = b ? int'($urandom_range(70, 60)) : int'($urandom_range(30, 20));
    send_bit(h, int'($urandom_range(8, 2)));
  endtask

  task automatic send_rword(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_rbit(w[i]);
  endtask

  // Nominal datasheet timing: 0 = 400/850 ns, 1 = 800/450 ns.
  task automatic send_std_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) send_bit(80, 45);
      else      send_bit(40, 85);
    end
  endtask

  task automatic chk_cv(input string tag, input int k, input logic [23:0] w, input int idx);
    if (cv_q.size() > k) begin
      chk({tag, "_word"}, longint'(cv_q[k].w), longint'(w));
      chk({tag, "_idx"}, longint'(cv_q[k].idx), longint'(idx));
    end else begin
      chk({tag, "_present"}, 0, 1);
    end
  endtask

  initial begin
    logic [23:0] ws[21];
    logic [23:0] w2, w3, w4;
    longint      f_err;

    // Reset state
    strand_in = 1'b0;
    rst_in    = 1'b0;
    hold_low(3);
    chk("reset_outputs",
        longint'({green_out, red_out, blue_out, led_index_out, color_valid, frame_done, error}), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    hold_low(4500);
    chk("startup_quiet", longint'(cv_q.size() + fd_q.size() + er_q.size()), 0);

    // Single word at nominal timing
    clr();
    send_std_word(24'hFF00AA);
    hold_low(10);
    chk("t1_cv_count", cv_q.size(), 1);
    chk_cv("t1", 0, 24'hFF00AA, 0);
    if (cv_q.size() > 0) chk("t1_latency", cv_q[0].t - last_fall, 2);
    chk("t1_green", longint'(green_out), 'hFF);
    chk("t1_red", longint'(red_out), 'h00);
    chk("t1_blue", longint'(blue_out), 'hAA);
    chk("t1_no_error", er_q.size(), 0);
    hold_low(4100);
    chk("t1_frame_done", fd_q.size(), 1);

    // Three words, 50 us gap
    clr();
    send_rword(24'h123456);
    send_rword(24'hABCDEF);
    send_rword(24'h000001);
    hold_low(5000);
    chk("t2_cv_count", cv_q.size(), 3);
    chk_cv("t2_w0", 0, 24'h123456, 0);
    chk_cv("t2_w1", 1, 24'hABCDEF, 1);
    chk_cv("t2_w2", 2, 24'h000001, 2);
    chk("t2_fd_count", fd_q.size(), 1);
    if (fd_q.size() > 0)
      chk("t2_fd_timing", longint'((fd_q[0] - last_fall >= 3998) && (fd_q[0] - last_fall <= 4004)), 1);
    chk("t2_no_error", er_q.size(), 0);

    // Width boundaries: 60/100 decode as 1, 59/20 as 0
    clr();
    for (int i = 0; i < 24; i++) send_bit((i % 2 == 0) ? 60 : 59, 5);
    for (int i = 0; i < 24; i++) send_bit((i % 2 == 0) ? 20 : 100, 5);
    hold_low(4100);
    chk("t3_cv_count", cv_q.size(), 2);
    chk_cv("t3_60_59", 0, 24'hAAAAAA, 0);
    chk_cv("t3_20_100", 1, 24'h555555, 1);
    chk("t3_no_error", er_q.size(), 0);
    chk("t3_fd_count", fd_q.size(), 1);

    // 19-cycle pulse errors, following word ignored until a gap
    clr();
    send_bit(19, 10);
    f_err = last_fall;
    w2 = 24'($urandom);
    send_rword(w2);
    hold_low(4100);
    chk("t4_short_err_count", er_q.size(), 1);
    if (er_q.size() > 0) chk("t4_short_err_time", er_q[0] - f_err, 2);
    chk("t4_ignored_cv", cv_q.size(), 0);
    chk("t4_no_fd", fd_q.size(), 0);
    clr();
    w3 = 24'($urandom);
    send_rword(w3);
    hold_low(10);
    chk("t4_resync_count", cv_q.size(), 1);
    chk_cv("t4_resync", 0, w3, 0);
    clr();
    send_bit(101, 10);
    chk("t4_long_err_count", er_q.size(), 1);
    if (er_q.size() > 0) chk("t4_long_err_time", er_q[0] - last_fall, 2);
    hold_low(4100);
    chk("t4_long_no_fd", fd_q.size(), 0);
    chk("t4_long_no_cv", cv_q.size(), 0);

    // Partial word (12 bits) then gap
    clr();
    for (int i = 0; i < 12; i++) send_rbit(1'($urandom));
    hold_low(5000);
    chk("t5_err_count", er_q.size(), 1);
    if (er_q.size() > 0)
      chk("t5_err_timing", longint'((er_q[0] - last_fall >= 3998) && (er_q[0] - last_fall <= 4004)), 1);
    chk("t5_no_cv", cv_q.size(), 0);
    chk("t5_no_fd", fd_q.size(), 0);

    // 21 words into a 20-LED decoder
    clr();
    for (int i = 0; i < 21; i++) ws[i] = 24'($urandom);
    ws[19] = ws[19] | 24'h800001;
    for (int i = 0; i < 21; i++) send_rword(ws[i]);
    hold_low(10);
    chk("t6_cv_count", cv_q.size(), NL);
    for (int i = 0; i < NL; i++) chk_cv("t6", i, ws[i], i);
    chk("t6_err_count", er_q.size(), 1);
    if (er_q.size() > 0) chk("t6_err_time", er_q[0] - last_fall, 2);
    chk("t6_outputs_held", longint'({green_out, red_out, blue_out}), longint'(ws[19]));
    chk("t6_index_held", longint'(led_index_out), 19);
    hold_low(4100);
    chk("t6_no_fd", fd_q.size(), 0);

    // Asynchronous reset mid-word
    clr();
    for (int i = 0; i < 10; i++) send_rbit(1'($urandom));
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("t7_async_reset",
        longint'({green_out, red_out, blue_out, led_index_out, color_valid, frame_done, error}), 0);
    hold_low(3);
    rst_in = 1'b1;
    clr();
    w4 = 24'($urandom);
    send_rword(w4);
    hold_low(10);
    chk("t7_no_cv_before_gap", cv_q.size(), 0);
    hold_low(4100);
    chk("t7_gap_quiet", longint'(fd_q.size() + er_q.size()), 0);
    w4 = 24'($urandom);
    send_rword(w4);
    hold_low(10);
    chk("t7_cv_count", cv_q.size(), 1);
    chk_cv("t7_after_gap", 0, w4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812b_decoder.md
# ws2812b_decoder

Receives a WS2812B single-wire strand, such as the `led_driver` output looped back or a panel's DOUT, and turns it back into per-LED 24-bit GRB words. It measures each high pulse width to classify bits, assembles words MSB-first, tags each word with its LED index, and detects the reset (latch) gap as the frame boundary. It serves as a self-check/monitor for the LED output path and as an input port for strands driven by external controllers.

## Interface
- `CLOCK_SPEED`, default 100_000_000: clock frequency in Hz; all timing thresholds derive from it.
- `NUM_LEDS`, default 20: maximum words accepted per frame; `CounterWidth = $clog2(NUM_LEDS)`.
- `clk_in`  input  1  single system clock.
- `rst_in`  input  1  reset, asynchronous, active-low.
- `strand_in`  input  1  raw asynchronous strand line.
- `green_out`, `red_out`, `blue_out`  output  8 each  last decoded word; hold value between words.
- `led_index_out`  output  CounterWidth  index of the word on `*_out`; hold value.
- `color_valid`  output  1  one-cycle pulse when a complete word is presented.
- `frame_done`  output  1  one-cycle pulse on reset gap after a frame with at least one word.
- `error`  output  1  one-cycle pulse on any protocol violation.

## Operation
- Derived cycle counts use ns × CLOCK_SPEED / 1e9, truncated. At 100 MHz they are:
  - TMinHCyc = 20 (200 ns)
  - TThrCyc = 60 (600 ns)
  - TMaxHCyc = 100 (1000 ns)
  - ResCyc = 4000 (40 µs detection)
- `strand_in` passes through a 2-flop synchronizer (s2), then a registered copy (s2_d) for edge detection.
  - Rise = s2 & !s2_d.
  - Fall = !s2 & s2_d.
- High counter: cleared on rise, incremented each cycle s2 is high, saturates at TMaxHCyc+1.
- Low counter: cleared on fall, incremented each cycle s2 is low, saturates at ResCyc.
- States:
  - SYNC (entered on reset):
    - Any high clears the low counter.
    - Low counter reaching ResCyc → go to ARMED, clear bit/LED counters. No pulses are emitted.
  - ARMED (line low, between bits):
    - Rise → HIGH.
    - Low counter reaching ResCyc (the single cycle it becomes ResCyc):
      - Clear the bit counter and LED counter.
      - If the bit counter ≠ 0 → `error`.
      - Else if at least one word was received this frame → `frame_done`.
      - Stay in ARMED.
  - HIGH:
    - High counter exceeding TMaxHCyc → `error`, go to SYNC.
    - Fall with high count < TMinHCyc → `error`, go to SYNC.
    - Fall otherwise: bit = (high count ≥ TThrCyc). Shift the bit into the 24-bit register (MSB first: G7..G0, R7..R0, B7..B0), increment the bit counter, go to ARMED.
- On the 24th bit (bit counter 0..23 wraps to 0):
  - If LED count < NUM_LEDS: load `*_out` from the shift register including the current bit, load `led_index_out`, pulse `color_valid`, increment the LED count.
  - Else: pulse `error`, drop the word, keep outputs unchanged.
- Any error returns to SYNC. Words are ignored until a full ResCyc low gap is seen.
- Low-phase length between bits is not checked, except for reset detection.
- When `error` and `frame_done` would coincide, only `error` pulses.

## Timing
- While `rst_in` is low (asynchronously): all outputs 0, state SYNC, all counters 0, synchronizer flops 0.
- After reset release, data is accepted only after ≥ ResCyc cycles of synchronized low.
- Pin-to-detect latency: edge N samples the new pin level; the edge is detected combinationally after edge N+1. Registered results (`color_valid`, `error`, `frame_done`, `*_out`) change at edge N+2 and pulse for exactly one cycle.
- High-width measurement counts synchronized cycles. The 2-cycle synchronizer delay is identical on both edges, so the width is preserved ±1 cycle.
- Minimum word period is 24 × (TMinHCyc + 2) cycles. There is no backpressure; consumers must take `color_valid` pulses as they come.
- The LED counter saturates at NUM_LEDS, so `led_index_out` never exceeds NUM_LEDS−1.

## Test plan
- Reset, hold the line low for 45 µs, then send G=0xFF R=0x00 B=0xAA at 400/850 ns and 800/450 ns bit timing → one `color_valid` 2 cycles after the last fall, outputs FF/00/AA, index 0, `error`=0.
- Send three words (0x123456, 0xABCDEF, 0x000001), then hold low 50 µs → `color_valid` with indices 0, 1, 2, then exactly one `frame_done` 4000 cycles after the last fall.
- Threshold boundaries:
  - High widths of 59, 60, 19 and 101 cycles decode as 0, 1, `error`, and `error`.
  - After an `error`, the next word produces no `color_valid` until a 40 µs low gap has been seen.
- Send 12 bits, then hold low 50 µs → `error` pulse at gap detection, no `color_valid`, no `frame_done`.
- Send 21 words in one frame → 20 `color_valid` pulses with indices 0..19; the 21st word gives `error` with outputs unchanged; the following gap gives no `frame_done`.
- Assert `rst_in` mid-word (after bit 10) → outputs go to 0 immediately without a clock edge. After release, a word sent without a preceding 40 µs gap is ignored; after a gap it decodes correctly at index 0.
